seg_message_checker: RTL and testbench

Receive-side companion to the 7-segment message sequencer. Watches a segment bus (dp,a..g) plus an asynchronous advance strobe, which is a button or a sequencer clock line. Each strobe rising edge is synchronized and debounced, then the segment pattern is decoded back to a character code. The block checks the decoded stream against the fixed 14-frame message "dp S E n O L G U L G O n U L" and reports lock, completed messages and errors.

---
 rtl/seg_message_checker.sv | 191 +++++++++++++++++++
 tb/tb_seg_message_checker.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seg_message_checker.sv
// rtl/seg_message_checker.sv - 7-segment message checker with debounced advance strobe
// Decodes captured segment frames and tracks them against the fixed 14-frame message.
module seg_message_checker #(
    parameter int DEB_CYCLES = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       seg_in,
    input  logic             strobe,
    output logic [3:0]       char_code,
    output logic             char_valid,
    output logic             seg_error,
    output logic [3:0]       expect_pos,
    output logic             locked,
    output logic             msg_done,
    output logic [7:0]       msg_count,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
    localparam logic [3:0] LAST_POS = 4'd13;

    logic             r_sync1, r_sync2;
    logic             r_deb, r_deb_d;
    logic [3:0]       r_deb_cnt;
    logic             w_deb_rise;

    logic [3:0]       w_code;
    logic             w_unknown;
    logic [3:0]       r_char_code;
    logic             r_char_valid;
    logic             r_seg_error;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_expect_pos, w_pos_nxt;
    logic [7:0]       r_msg_count, w_msg_cnt_nxt;
    logic [ERR_W-1:0] r_err_count, w_err_nxt;
    logic             r_msg_done, w_done_nxt;

    function automatic logic [3:0] exp_code(input logic [3:0] pos);
        case (pos)
            4'd0:    exp_code = 4'd0;
            4'd1:    exp_code = 4'd1;
            4'd2:    exp_code = 4'd2;
            4'd3:    exp_code = 4'd3;
            4'd4:    exp_code = 4'd4;
            4'd5:    exp_code = 4'd5;
            4'd6:    exp_code = 4'd6;
            4'd7:    exp_code = 4'd7;
            4'd8:    exp_code = 4'd5;
            4'd9:    exp_code = 4'd6;
            4'd10:   exp_code = 4'd4;
            4'd11:   exp_code = 4'd3;
            4'd12:   exp_code = 4'd7;
            4'd13:   exp_code = 4'd5;
            default: exp_code = 4'd15;
        endcase
    endfunction

    // Strobe synchronizer and debouncer: deb flips only after DEB_CYCLES differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_deb     <= 1'b0;
            r_deb_d   <= 1'b0;
            r_deb_cnt <= 4'd0;
        end else begin
            r_sync1 <= strobe;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (r_sync2 == r_deb) begin
                r_deb_cnt <= 4'd0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_deb     <= ~r_deb;
                r_deb_cnt <= 4'd0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 4'd1;
            end
        end
    end

    assign w_deb_rise = r_deb & ~r_deb_d;

    always_comb begin
        w_unknown = 1'b0;
        case (seg_in)
            8'h80:   w_code = 4'd0;
            8'h5B:   w_code = 4'd1;
            8'h4F:   w_code = 4'd2;
            8'h15:   w_code = 4'd3;
            8'h7E:   w_code = 4'd4;
            8'h0E:   w_code = 4'd5;
            8'h5F:   w_code = 4'd6;
            8'h3E:   w_code = 4'd7;
            default: begin
                w_code    = 4'd15;
                w_unknown = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char_code  <= 4'd0;
            r_char_valid <= 1'b0;
            r_seg_error  <= 1'b0;
        end else begin
            r_char_valid <= w_deb_rise;
            r_seg_error  <= w_deb_rise & w_unknown;
            if (w_deb_rise) begin
                r_char_code <= w_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= HUNT;
            r_expect_pos <= 4'd0;
            r_msg_count  <= 8'd0;
            r_err_count  <= '0;
            r_msg_done   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_expect_pos <= w_pos_nxt;
            r_msg_count  <= w_msg_cnt_nxt;
            r_err_count  <= w_err_nxt;
            r_msg_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pos_nxt     = r_expect_pos;
        w_msg_cnt_nxt = r_msg_count;
        w_err_nxt     = r_err_count;
        w_done_nxt    = 1'b0;
        if (w_deb_rise) begin
            case (r_state)
                HUNT: begin
                    if (w_code == 4'd0) begin
                        w_state_nxt = TRACK;
                        w_pos_nxt   = 4'd1;
                    end
                end
                TRACK: begin
                    if (w_code == exp_code(r_expect_pos)) begin
                        if (r_expect_pos == LAST_POS) begin
                            w_done_nxt    = 1'b1;
                            w_msg_cnt_nxt = r_msg_count + 8'd1;
                            w_pos_nxt     = 4'd0;
                        end else begin
                            w_pos_nxt = r_expect_pos + 4'd1;
                        end
                    end else begin
                        if (r_err_count != '1) begin
                            w_err_nxt = r_err_count + ERR_W'(1);
                        end
                        // A stray DP frame is treated as the start of a new message
                        if (w_code == 4'd0) begin
                            w_pos_nxt = 4'd1;
                        end else begin
                            w_state_nxt = HUNT;
                            w_pos_nxt   = 4'd0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_pos_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        locked     = (r_state == TRACK);
        expect_pos = r_expect_pos;
        msg_done   = r_msg_done;
        msg_count  = r_msg_count;
        err_count  = r_err_count;
        char_code  = r_char_code;
        char_valid = r_char_valid;
        seg_error  = r_seg_error;
    end

endmodule

// File: tb/tb_seg_message_checker.sv
// tb/tb_seg_message_checker.sv - directed bench for seg_message_checker
module tb_seg_message_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seg_in;
    logic       strobe;

    logic [3:0] char_code, expect_pos;
    logic       char_valid, seg_error, locked, msg_done;
    logic [7:0] msg_count, err_count;

    logic [3:0] d2_char_code, d2_expect_pos;
    logic       d2_char_valid, d2_seg_error, d2_locked, d2_msg_done;
    logic [7:0] d2_msg_count;
    logic [1:0] d2_err_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] segs  [14] = '{8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F,
                               8'h3E, 8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E};
    logic [3:0] codes [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd5, 4'd6, 4'd4, 4'd3, 4'd7, 4'd5};

    always #5 clk = ~clk;

    seg_message_checker #(.DEB_CYCLES(4), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .strobe(strobe),
        .char_code(char_code), .char_valid(char_valid), .seg_error(seg_error),
        .expect_pos(expect_pos), .locked(locked), .msg_done(msg_done),
        .msg_count(msg_count), .err_count(err_count)
    );

    seg_message_checker #(.DEB_CYCLES(4), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .strobe(strobe),
        .char_code(d2_char_code), .char_valid(d2_char_valid), .seg_error(d2_seg_error),
        .expect_pos(d2_expect_pos), .locked(d2_locked), .msg_done(d2_msg_done),
        .msg_count(d2_msg_count), .err_count(d2_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One strobe frame: char_valid must be low after edge 6 and high after edge 7
    task automatic frame(input logic [7:0] seg, input logic [3:0] code, input logic err,
                         input logic lk, input logic [3:0] pos, input logic done);
        @(negedge clk);
        seg_in = seg;
        repeat (2) @(negedge clk);
        strobe = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 6) chk("pre_valid", {31'd0, char_valid}, 32'd0);
        end
        chk($sformatf("frame_%02h", seg),
            {22'd0, char_valid, char_code, seg_error, locked, expect_pos, msg_done},
            {22'd0, 1'b1, code, err, lk, pos, done});
        repeat (3) @(posedge clk);
        @(negedge clk);
        strobe = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int seen;
        rst_n  = 1'b0;
        seg_in = 8'h00;
        strobe = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state",
            {4'd0, char_code, char_valid, seg_error, expect_pos, locked, msg_done, msg_count, err_count},
            32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 3-cycle glitch must be filtered
        seg_in = 8'h5B;
        repeat (2) @(negedge clk);
        strobe = 1'b1;
        repeat (3) @(negedge clk);
        strobe = 1'b0;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            if (char_valid) seen++;
        end
        chk("glitch_no_valid", seen, 0);
        frame(8'h5B, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("hunt_no_err", {24'd0, err_count}, 32'd0);

        for (int i = 0; i < 14; i++)
            frame(segs[i], codes[i], 1'b0, 1'b1, (i == 13) ? 4'd0 : 4'(i + 1), i == 13);
        chk("msg_count_1", {24'd0, msg_count}, 32'd1);
        chk("err_count_0", {24'd0, err_count}, 32'd0);

        frame(8'h80, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        frame(8'h5B, 4'd1, 1'b0, 1'b1, 4'd2, 1'b0);
        frame(8'h4F, 4'd2, 1'b0, 1'b1, 4'd3, 1'b0);
        frame(8'h4F, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("mismatch_err_1", {24'd0, err_count}, 32'd1);
        frame(8'h80, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);

        frame(8'h5B, 4'd1, 1'b0, 1'b1, 4'd2, 1'b0);
        frame(8'h4F, 4'd2, 1'b0, 1'b1, 4'd3, 1'b0);
        frame(8'h15, 4'd3, 1'b0, 1'b1, 4'd4, 1'b0);
        frame(8'h7E, 4'd4, 1'b0, 1'b1, 4'd5, 1'b0);
        frame(8'h80, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        chk("resync_err_2", {24'd0, err_count}, 32'd2);
        chk("d2_err_2", {30'd0, d2_err_count}, 32'd2);

        frame(8'h01, 4'd15, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("unknown_track_err_3", {24'd0, err_count}, 32'd3);
        frame(8'h01, 4'd15, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("unknown_hunt_err_3", {24'd0, err_count}, 32'd3);

        frame(8'h80, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++)
            frame(8'h80, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        chk("err_after_5_more", {24'd0, err_count}, 32'd8);
        chk("d2_err_saturated", {30'd0, d2_err_count}, 32'd3);

        for (int i = 1; i < 14; i++)
            frame(segs[i], codes[i], 1'b0, 1'b1, (i == 13) ? 4'd0 : 4'(i + 1), i == 13);
        for (int i = 0; i < 9; i++)
            frame(segs[i], codes[i], 1'b0, 1'b1, 4'(i + 1), 1'b0);
        chk("pre_reset_pos_msgs", {20'd0, expect_pos, msg_count}, {20'd0, 4'd9, 8'd2});

        // Reset mid-debounce, strobe kept high across release
        @(negedge clk);
        seg_in = 8'h5F;
        repeat (2) @(negedge clk);
        strobe = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset",
            {4'd0, char_code, char_valid, seg_error, expect_pos, locked, msg_done, msg_count, err_count},
            32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (char_valid) seen++;
            if (k == 7)
                chk("post_reset_frame",
                    {23'd0, char_valid, char_code, locked, expect_pos},
                    {23'd0, 1'b1, 4'd6, 1'b0, 4'd0});
        end
        chk("post_reset_one_frame", seen, 1);
        strobe = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
